fetch_halt_ctrl: RTL and testbench
==================================

FETCH_HALT_CTRL -- requirements
Module: fetch_halt_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, ports clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 if_instr  input  16  instruction-memory data at address pc.
REQ-005 stall  input  1  hazard-unit hold of the PC and the IF/ID register.
REQ-006 branch_taken  input  1  EX-stage redirect; flushes IF/ID.
REQ-007 branch_target  input  16  redirect address, valid when branch_taken=1.
REQ-008 pc  output  16  fetch address (registered).
REQ-009 id_instr  output  16  IF/ID instruction (registered).
REQ-010 id_pc_plus2  output  16  IF/ID copy of fetch pc+2 (registered).
REQ-011 id_valid  output  1  IF/ID holds a real instruction; 0 = bubble.
REQ-012 hlt_found  output  1  combinational one-cycle pulse: HLT leaves ID for EX; drives the downstream halt pipeline.
REQ-013 fetch_halted  output  1  registered; 1 while in state HALTED.

Function
REQ-014 SHALL implement states RUN, DRAIN, HALTED; HLT = opcode bits [15:12] == 4'hF.
REQ-015 Per-edge priority: reset > branch_taken > stall > normal advance.
REQ-016 Bubble load: id_instr=16'h0000, id_pc_plus2=16'h0000, id_valid=0.
REQ-017 RUN, branch_taken=1: pc<=branch_target, IF/ID<=bubble, stay RUN; a HLT on if_instr that cycle is squashed.
REQ-018 RUN, stall=1 (no branch): pc and IF/ID hold; a HLT on if_instr causes no transition.
REQ-019 RUN, advance, if_instr not HLT: pc<=pc+2, IF/ID<={if_instr, pc+2, valid=1}.
REQ-020 RUN, advance, if_instr is HLT: IF/ID<={if_instr, pc+2, valid=1}, pc holds, next state DRAIN.
REQ-021 pc+2 is 16-bit modular: 16'hFFFE advances to 16'h0000; no carry out.
REQ-022 DRAIN, branch_taken=1: pc<=branch_target, IF/ID<=bubble, next state RUN; hlt_found stays 0 (HLT was wrong-path).
REQ-023 DRAIN, stall=1 (no branch): pc, IF/ID, state hold; hlt_found=0.
REQ-024 DRAIN, advance: hlt_found=1 during that cycle, IF/ID<=bubble, pc holds, next state HALTED.
REQ-025 hlt_found = (state==DRAIN) & id_valid & id_instr[15:12]==4'hF & ~stall & ~branch_taken; it SHALL pulse exactly once per committed HLT.
REQ-026 HALTED: pc frozen, IF/ID bubble, stall and branch_taken ignored, hlt_found=0; exit only by reset.
REQ-027 fetch_halted SHALL rise on the edge entering HALTED and stay 1.

Reset
REQ-028 rst_n=0 SHALL immediately force pc=16'h0000, IF/ID bubble, state RUN, fetch_halted=0, regardless of clk.
REQ-029 Reset asserted in any state, including DRAIN or HALTED, SHALL discard pending HLT with no hlt_found pulse; first fetch after release is address 0.

Verification
REQ-030 Release reset, if_instr non-HLT each cycle -> pc 0,2,4,6; id_pc_plus2 trails by one cycle (2,4,6); id_valid=1 from cycle 1.
REQ-031 HLT (16'hF000) at pc=6 -> pc holds 6; next edge DRAIN; hlt_found=1 for exactly one cycle; following edge fetch_halted=1, id_valid=0; pc stays 6 for 10 further cycles with stall/branch toggling.
REQ-032 HLT in DRAIN with branch_taken=1, branch_target=16'h0040 -> hlt_found never asserts, pc=0x0040, state RUN, fetch resumes 0x0042.
REQ-033 HLT in ID with stall=1 for 3 cycles -> hlt_found=0 during stall, single pulse on cycle after stall drops.
REQ-034 branch_taken and stall both 1 in RUN, target 16'h0100 -> pc=0x0100, id_valid=0; pc=16'hFFFE advance -> pc=0x0000.
REQ-035 rst_n pulled low mid-cycle while HALTED -> pc=0, fetch_halted=0 before next clk edge; normal fetch resumes after release.

Source files
------------

// File: rtl/fetch_halt_ctrl.sv
// rtl/fetch_halt_ctrl.sv - IF stage PC / IF-ID register with HLT drain-and-freeze control
module fetch_halt_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] if_instr,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic [15:0] pc,
    output logic [15:0] id_instr,
    output logic [15:0] id_pc_plus2,
    output logic        id_valid,
    output logic        hlt_found,
    output logic        fetch_halted
);

    localparam logic [3:0]  HLT_OPCODE = 4'hF;
    localparam logic [15:0] PC_RESET   = 16'h0000;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] id_instr_q, id_instr_d;
    logic [15:0] id_pc_plus2_q, id_pc_plus2_d;
    logic        id_valid_q, id_valid_d;
    logic        fetch_halted_q, fetch_halted_d;

    logic [15:0] pc_plus2;
    logic        if_is_hlt;
    logic        id_is_hlt;
    logic        hlt_commit;

    // Modular add: 16'hFFFE wraps to 16'h0000.
    assign pc_plus2  = pc_q + 16'd2;
    assign if_is_hlt = (if_instr[15:12] == HLT_OPCODE);
    assign id_is_hlt = (id_instr_q[15:12] == HLT_OPCODE);

    // HLT commits only when it actually moves from ID into EX.
    assign hlt_commit = (state_q == ST_DRAIN) & id_valid_q & id_is_hlt
                      & ~stall & ~branch_taken;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        id_instr_d    = id_instr_q;
        id_pc_plus2_d = id_pc_plus2_q;
        id_valid_d    = id_valid_q;

        unique case (state_q)
            ST_RUN: begin
                if (branch_taken) begin
                    pc_d          = branch_target;
                    id_instr_d    = 16'h0000;
                    id_pc_plus2_d = 16'h0000;
                    id_valid_d    = 1'b0;
                end else if (!stall) begin
                    id_instr_d    = if_instr;
                    id_pc_plus2_d = pc_plus2;
                    id_valid_d    = 1'b1;
                    if (if_is_hlt) begin
                        state_d = ST_DRAIN;
                    end else begin
                        pc_d = pc_plus2;
                    end
                end
            end
            ST_DRAIN: begin
                // The HLT sits in ID; a redirect means it was on the wrong path.
                if (branch_taken) begin
                    pc_d          = branch_target;
                    id_instr_d    = 16'h0000;
                    id_pc_plus2_d = 16'h0000;
                    id_valid_d    = 1'b0;
                    state_d       = ST_RUN;
                end else if (!stall) begin
                    id_instr_d    = 16'h0000;
                    id_pc_plus2_d = 16'h0000;
                    id_valid_d    = 1'b0;
                    state_d       = ST_HALTED;
                end
            end
            ST_HALTED: begin
                id_instr_d    = 16'h0000;
                id_pc_plus2_d = 16'h0000;
                id_valid_d    = 1'b0;
            end
            default: begin
                state_d       = ST_RUN;
                pc_d          = PC_RESET;
                id_instr_d    = 16'h0000;
                id_pc_plus2_d = 16'h0000;
                id_valid_d    = 1'b0;
            end
        endcase

        fetch_halted_d = (state_d == ST_HALTED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_RUN;
            pc_q           <= PC_RESET;
            id_instr_q     <= 16'h0000;
            id_pc_plus2_q  <= 16'h0000;
            id_valid_q     <= 1'b0;
            fetch_halted_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            id_instr_q     <= id_instr_d;
            id_pc_plus2_q  <= id_pc_plus2_d;
            id_valid_q     <= id_valid_d;
            fetch_halted_q <= fetch_halted_d;
        end
    end

    assign pc           = pc_q;
    assign id_instr     = id_instr_q;
    assign id_pc_plus2  = id_pc_plus2_q;
    assign id_valid     = id_valid_q;
    assign hlt_found    = hlt_commit;
    assign fetch_halted = fetch_halted_q;

endmodule

// File: tb/tb_fetch_halt_ctrl.sv
// tb/tb_fetch_halt_ctrl.sv - scoreboard bench for fetch_halt_ctrl
module tb_fetch_halt_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] if_instr;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] pc;
    logic [15:0] id_instr;
    logic [15:0] id_pc_plus2;
    logic        id_valid;
    logic        hlt_found;
    logic        fetch_halted;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] ii;
        logic [15:0] ipp;
        logic        iv;
        logic        hf;
        logic        fh;
    } obs_t;

    obs_t exp_q[$];
    int   tag_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;
    bit   done = 0;

    fetch_halt_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_instr      (if_instr),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc),
        .id_instr      (id_instr),
        .id_pc_plus2   (id_pc_plus2),
        .id_valid      (id_valid),
        .hlt_found     (hlt_found),
        .fetch_halted  (fetch_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o.pc  = pc;
        o.ii  = id_instr;
        o.ipp = id_pc_plus2;
        o.iv  = id_valid;
        o.hf  = hlt_found;
        o.fh  = fetch_halted;
        return o;
    endfunction

    task automatic compare(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got pc=%h ii=%h ipp=%h iv=%b hf=%b fh=%b, expected pc=%h ii=%h ipp=%h iv=%b hf=%b fh=%b",
                     name, got.pc, got.ii, got.ipp, got.iv, got.hf, got.fh,
                     exp.pc, exp.ii, exp.ipp, exp.iv, exp.hf, exp.fh);
        end
    endtask

    // Monitor: every cycle the DUT presents a new observation on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t e;
            int   t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            compare($sformatf("step%0d", t), sample(), e);
        end
    end

    task automatic step(input logic [15:0] instr, input logic st, input logic br,
                        input logic [15:0] tgt,
                        input logic [15:0] e_pc, input logic [15:0] e_ii,
                        input logic [15:0] e_ipp, input logic e_iv,
                        input logic e_hf, input logic e_fh);
        obs_t e;
        if_instr      = instr;
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        e.pc  = e_pc;
        e.ii  = e_ii;
        e.ipp = e_ipp;
        e.iv  = e_iv;
        e.hf  = e_hf;
        e.fh  = e_fh;
        exp_q.push_back(e);
        tag_q.push_back(step_no);
        step_no++;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset mid-cycle: outputs must clear before any clock edge.
    task automatic async_reset(input string name);
        obs_t e;
        @(negedge clk);
        #1;
        stall        = 1'b0;
        branch_taken = 1'b0;
        rst_n        = 1'b0;
        #1;
        e = '0;
        compare(name, sample(), e);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        if_instr      = 16'h0000;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Sequential fetch, then HLT at pc=6.
        step(16'h1234, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        step(16'h2222, 0, 0, 16'h0000, 16'h0002, 16'h1234, 16'h0002, 1, 0, 0);
        step(16'h3333, 0, 0, 16'h0000, 16'h0004, 16'h2222, 16'h0004, 1, 0, 0);
        step(16'hF000, 0, 0, 16'h0000, 16'h0006, 16'h3333, 16'h0006, 1, 0, 0);
        step(16'h4444, 0, 0, 16'h0000, 16'h0006, 16'hF000, 16'h0008, 1, 1, 0);
        for (int i = 0; i < 11; i++) begin
            step(16'hF000, i[0], i[1], 16'h1234, 16'h0006, 16'h0000, 16'h0000, 0, 0, 1);
        end

        async_reset("reset_in_halted");

        // HLT squashed by a redirect while draining, then stalled HLT commit.
        step(16'h1111, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        step(16'hF000, 0, 0, 16'h0000, 16'h0002, 16'h1111, 16'h0002, 1, 0, 0);
        step(16'h5555, 0, 1, 16'h0040, 16'h0002, 16'hF000, 16'h0004, 1, 0, 0);
        step(16'h6666, 0, 0, 16'h0000, 16'h0040, 16'h0000, 16'h0000, 0, 0, 0);
        step(16'hF000, 0, 0, 16'h0000, 16'h0042, 16'h6666, 16'h0042, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(16'h7777, 1, 0, 16'h0000, 16'h0042, 16'hF000, 16'h0044, 1, 0, 0);
        end
        step(16'h7777, 0, 0, 16'h0000, 16'h0042, 16'hF000, 16'h0044, 1, 1, 0);
        step(16'h7777, 0, 0, 16'h0000, 16'h0042, 16'h0000, 16'h0000, 0, 0, 1);

        async_reset("reset_in_halted_2");

        // Branch beats stall, stalled HLT ignored, pc wrap, HLT squashed in RUN.
        step(16'h7777, 1, 1, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        step(16'hF000, 1, 0, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 0, 0, 0);
        step(16'h8888, 0, 1, 16'hFFFE, 16'h0100, 16'h0000, 16'h0000, 0, 0, 0);
        step(16'h9999, 0, 0, 16'h0000, 16'hFFFE, 16'h0000, 16'h0000, 0, 0, 0);
        step(16'hA0A0, 0, 0, 16'h0000, 16'h0000, 16'h9999, 16'h0000, 1, 0, 0);
        step(16'hF000, 0, 1, 16'h0200, 16'h0002, 16'hA0A0, 16'h0002, 1, 0, 0);
        step(16'h1000, 0, 0, 16'h0000, 16'h0200, 16'h0000, 16'h0000, 0, 0, 0);
        step(16'hF000, 0, 0, 16'h0000, 16'h0202, 16'h1000, 16'h0202, 1, 0, 0);
        step(16'h1000, 1, 0, 16'h0000, 16'h0202, 16'hF000, 16'h0204, 1, 0, 0);

        async_reset("reset_in_drain");

        step(16'h2000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        step(16'h0000, 0, 0, 16'h0000, 16'h0002, 16'h2000, 16'h0002, 1, 0, 0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue: got %0d pending, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no completion, expected finish");
        $fatal(1, "timeout");
    end

endmodule
